// File: rtl/score_overlay_pkg.sv
// Shared types and constants for the score overlay: converter states,
// 7-segment patterns and the score/BCD widths.
package score_overlay_pkg;

    localparam int SCORE_W = 14;
    localparam int BCD_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Segment patterns ordered {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011   // 9
    };

    // Non-decimal nibbles map to an all-dark glyph
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'b0000000;
        if (nib <= 4'd9) s = SEG_LUT[nib];
        return s;
    endfunction

endpackage

// File: rtl/score_overlay_bin2bcd.sv
// Sequential shift/add-3 binary-to-BCD converter: one score bit per cycle,
// followed by a single COMMIT cycle that pulses done.
module bin2bcd_seq
    import score_overlay_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    conv_state_e        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   adj;

    // Control state: FSM and bit counter, cleared by reset to abort a conversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Working {bcd, bin} shift register; only meaningful while converting
    always_ff @(posedge clk) begin
        bcd_q <= bcd_d;
        bin_q <= bin_d;
    end

    // Add 3 to every nibble that would overflow past 9 after the next doubling
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy           = 1'b1;
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'(SCORE_W - 1)) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/score_overlay.sv
// Score overlay: converts the score to BCD once per frame and draws four
// 7-segment digits geometrically from the raster counters.
module score_overlay
    import score_overlay_pkg::*;
#(
    parameter logic [10:0] X0       = 11'd300,
    parameter logic [9:0]  Y0       = 10'd50,
    parameter int          DIG_W    = 25,
    parameter int          DIG_H    = 50,
    parameter int          GAP      = 5,
    parameter int          SEG_T    = 4,
    parameter logic [7:0]  FG       = 8'b111_111_00,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic [10:0]        count_h,
    input  logic [9:0]         count_v,
    output logic               pixel_on,
    output logic [7:0]         rgb,
    output logic               busy,
    output logic [BCD_W-1:0]   bcd_disp
);

    localparam logic [10:0] W11   = 11'(DIG_W);
    localparam logic [10:0] H11   = 11'(DIG_H);
    localparam logic [10:0] PITCH = 11'(DIG_W + GAP);
    localparam logic [10:0] T11   = 11'(SEG_T);
    localparam logic [10:0] H2    = 11'(DIG_H / 2);
    localparam logic [10:0] HT    = 11'(SEG_T / 2);
    localparam logic [10:0] Y_LO  = {1'b0, Y0} + 11'd1;

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
        return (s > SCORE_W'(9999)) ? SCORE_W'(9999) : s;
    endfunction

    function automatic logic [10:0] cell_lo(input int k);
        return X0 + 11'd1 + 11'(k) * PITCH;
    endfunction

    logic               frame_start, conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [BCD_W-1:0]   bcd_disp_q, bcd_disp_d;
    logic               pixel_on_q, pixel_on_d;
    logic [7:0]         rgb_q, rgb_d;

    logic [10:0] v11, x_loc, y_loc;
    logic        in_rows, in_cell, blank;
    logic [1:0]  dig_sel;
    logic [3:0]  nib;
    logic [3:0]  lz;
    logic [6:0]  seg;
    logic        r_a, r_d, r_g, r_left, r_right, r_top;

    // A frame start while a conversion is running is dropped
    assign frame_start = (count_h == 11'd0) && (count_v == 10'd0);
    assign conv_start  = frame_start && !conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (sat_score(score)),
        .busy  (conv_busy),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    assign bcd_disp_d = conv_done ? conv_bcd : bcd_disp_q;

    // Displayed value only moves in the COMMIT cycle so digits never tear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bcd_disp_q <= '0;
        else     bcd_disp_q <= bcd_disp_d;
    end

    // Digit-cell decode: bounds are checked before any subtraction
    always_comb begin
        v11     = {1'b0, count_v};
        in_rows = (v11 >= Y_LO) && (v11 < Y_LO + H11);
        y_loc   = in_rows ? (v11 - Y_LO) : 11'd0;
        in_cell = 1'b0;
        dig_sel = 2'd0;
        x_loc   = 11'd0;
        for (int k = 0; k < 4; k++) begin
            if ((count_h >= cell_lo(k)) && (count_h < cell_lo(k) + W11)) begin
                in_cell = 1'b1;
                dig_sel = 2'(k);
                x_loc   = count_h - cell_lo(k);
            end
        end
    end

    // Digit value selection and leading-zero blanking (digit 3 always drawn)
    always_comb begin
        case (dig_sel)
            2'd0:    nib = bcd_disp_q[15:12];
            2'd1:    nib = bcd_disp_q[11:8];
            2'd2:    nib = bcd_disp_q[7:4];
            default: nib = bcd_disp_q[3:0];
        endcase
        lz[0] = (bcd_disp_q[15:12] == 4'd0);
        lz[1] = lz[0] && (bcd_disp_q[11:8] == 4'd0);
        lz[2] = lz[1] && (bcd_disp_q[7:4] == 4'd0);
        lz[3] = 1'b0;
        blank = LZ_BLANK && lz[dig_sel];
        seg   = seg_decode(nib);
    end

    // Segment geometry within the cell
    always_comb begin
        r_a     = (y_loc < T11);
        r_d     = (y_loc >= H11 - T11);
        r_g     = (y_loc >= H2 - HT) && (y_loc < H2 + HT);
        r_left  = (x_loc < T11);
        r_right = (x_loc >= W11 - T11);
        r_top   = (y_loc < H2);
        pixel_on_d = in_rows && in_cell && !blank &&
                     ((seg[6] && r_a) ||
                      (seg[5] && r_right && r_top) ||
                      (seg[4] && r_right && !r_top) ||
                      (seg[3] && r_d) ||
                      (seg[2] && r_left && !r_top) ||
                      (seg[1] && r_left && r_top) ||
                      (seg[0] && r_g));
        rgb_d = pixel_on_d ? FG : 8'h00;
    end

    // One-cycle registered pixel output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_on_q <= 1'b0;
            rgb_q      <= 8'h00;
        end else begin
            pixel_on_q <= pixel_on_d;
            rgb_q      <= rgb_d;
        end
    end

    assign pixel_on = pixel_on_q;
    assign rgb      = rgb_q;
    assign busy     = conv_busy;
    assign bcd_disp = bcd_disp_q;

endmodule

// File: tb/tb_score_overlay.sv
// Directed self-checking bench for score_overlay.
module tb_score_overlay;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic [10:0] count_h;
    logic [9:0]  count_v;
    logic        pixel_on;
    logic [7:0]  rgb;
    logic        busy;
    logic [15:0] bcd_disp;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    score_overlay dut (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .count_h  (count_h),
        .count_v  (count_v),
        .pixel_on (pixel_on),
        .rgb      (rgb),
        .busy     (busy),
        .bcd_disp (bcd_disp)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus only: frame start with score s, then 16 more cycles (ends at t+17)
    task automatic do_convert(input logic [13:0] s);
        score   = s;
        count_h = 11'd0;
        count_v = 10'd0;
        @(posedge clk); #1;
        count_h = 11'd1;
        repeat (16) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        score   = 14'd0;
        count_h = 11'd400;
        count_v = 10'd52;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (pixel_on !== 1'b0 || rgb !== 8'h00 || busy !== 1'b0 || bcd_disp !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset[%0d]: pixel_on=%b rgb=%h busy=%b bcd_disp=%h, expected 0 00 0 0000",
                         i, pixel_on, rgb, busy, bcd_disp);
            end
            count_h = count_h + 11'd1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_conversion;
        int          scores [3] = '{12000, 37, 0};
        logic [15:0] exps   [3] = '{16'h9999, 16'h0037, 16'h0000};
        logic [15:0] prev;
        prev = bcd_disp;
        for (int n = 0; n < 3; n++) begin
            score   = 14'(scores[n]);
            count_h = 11'd0;
            count_v = 10'd0;
            @(posedge clk); #1;
            count_h = 11'd1;
            for (int c = 1; c <= 15; c++) begin
                n_chk++;
                if (busy !== 1'b1 || bcd_disp !== prev) begin
                    n_fail++;
                    $display("FAIL conv_busy score=%0d t+%0d: busy=%b bcd_disp=%h, expected 1 %h",
                             scores[n], c, busy, bcd_disp, prev);
                end
                @(posedge clk); #1;
            end
            n_chk++;
            if (busy !== 1'b0 || bcd_disp !== exps[n]) begin
                n_fail++;
                $display("FAIL conv_done score=%0d t+16: busy=%b bcd_disp=%h, expected 0 %h",
                         scores[n], busy, bcd_disp, exps[n]);
            end
            prev = exps[n];
        end
    endtask

    task automatic test_render_37;
        int hs [19] = '{403, 313, 326, 300, 403, 340, 361, 400, 413, 361,
                        370, 400, 415, 416, 370, 370, 385, 360, 392};
        int vs [19] = '{ 52,  52,  52,  52,  50,  52,  52,  76,  90,  90,
                         99,  99,  52,  52, 100, 101,  76,  52,  60};
        bit on [19] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0,
                        1, 0, 1, 0, 1, 0, 1, 0, 0};
        do_convert(14'd37);
        n_chk++;
        if (bcd_disp !== 16'h0037) begin
            n_fail++;
            $display("FAIL render37_value: bcd_disp=%h, expected 0037", bcd_disp);
        end
        for (int i = 0; i < 19; i++) begin
            count_h = 11'(hs[i]);
            count_v = 10'(vs[i]);
            @(posedge clk); #1;
            n_chk++;
            if (pixel_on !== on[i] || rgb !== (on[i] ? 8'hFC : 8'h00)) begin
                n_fail++;
                $display("FAIL render37 h=%0d v=%0d: pixel_on=%b rgb=%h, expected %b %h",
                         hs[i], vs[i], pixel_on, rgb, on[i], on[i] ? 8'hFC : 8'h00);
            end
        end
    endtask

    task automatic test_zero;
        int hs [6] = '{403, 400, 391, 361, 313, 331};
        int vs [6] = '{ 52,  76,  60,  52,  52,  52};
        bit on [6] = '{1, 0, 1, 0, 0, 0};
        do_convert(14'd0);
        n_chk++;
        if (bcd_disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_value: bcd_disp=%h, expected 0000", bcd_disp);
        end
        for (int i = 0; i < 6; i++) begin
            count_h = 11'(hs[i]);
            count_v = 10'(vs[i]);
            @(posedge clk); #1;
            n_chk++;
            if (pixel_on !== on[i]) begin
                n_fail++;
                $display("FAIL zero_render h=%0d v=%0d: pixel_on=%b, expected %b",
                         hs[i], vs[i], pixel_on, on[i]);
            end
        end
    endtask

    task automatic test_inner_zero;
        int hs [7] = '{340, 313, 323, 370, 413, 413, 392};
        int vs [7] = '{ 52,  52,  52,  52,  52,  60,  60};
        bit on [7] = '{1, 0, 1, 1, 1, 0, 1};
        do_convert(14'd1005);
        n_chk++;
        if (bcd_disp !== 16'h1005) begin
            n_fail++;
            $display("FAIL inner_zero_value: bcd_disp=%h, expected 1005", bcd_disp);
        end
        for (int i = 0; i < 7; i++) begin
            count_h = 11'(hs[i]);
            count_v = 10'(vs[i]);
            @(posedge clk); #1;
            n_chk++;
            if (pixel_on !== on[i]) begin
                n_fail++;
                $display("FAIL inner_zero_render h=%0d v=%0d: pixel_on=%b, expected %b",
                         hs[i], vs[i], pixel_on, on[i]);
            end
        end
    endtask

    task automatic test_midframe;
        do_convert(14'd5);
        score   = 14'd6;
        count_v = 10'd300;
        for (int i = 0; i < 20; i++) begin
            count_h = 11'(100 + i);
            @(posedge clk); #1;
            n_chk++;
            if (bcd_disp !== 16'h0005) begin
                n_fail++;
                $display("FAIL midframe_hold cyc=%0d: bcd_disp=%h, expected 0005", i, bcd_disp);
            end
        end
        count_h = 11'd0;
        count_v = 10'd0;
        @(posedge clk); #1;
        count_h = 11'd1;
        repeat (14) begin @(posedge clk); #1; end
        n_chk++;
        if (bcd_disp !== 16'h0005 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_t15: bcd_disp=%h busy=%b, expected 0005 1", bcd_disp, busy);
        end
        @(posedge clk); #1;
        n_chk++;
        if (bcd_disp !== 16'h0006 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_t16: bcd_disp=%h busy=%b, expected 0006 0", bcd_disp, busy);
        end
    endtask

    task automatic test_back_to_back;
        score   = 14'd1234;
        count_h = 11'd0;
        count_v = 10'd0;
        @(posedge clk); #1;
        count_h = 11'd1;
        repeat (4) begin @(posedge clk); #1; end
        score   = 14'd42;
        count_h = 11'd0;
        count_v = 10'd0;
        @(posedge clk); #1;
        count_h = 11'd1;
        score   = 14'd1234;
        repeat (10) begin @(posedge clk); #1; end
        n_chk++;
        if (busy !== 1'b0 || bcd_disp !== 16'h1234) begin
            n_fail++;
            $display("FAIL ignore_restart t+16: busy=%b bcd_disp=%h, expected 0 1234", busy, bcd_disp);
        end
        repeat (10) begin @(posedge clk); #1; end
        n_chk++;
        if (busy !== 1'b0 || bcd_disp !== 16'h1234) begin
            n_fail++;
            $display("FAIL ignore_restart_late: busy=%b bcd_disp=%h, expected 0 1234", busy, bcd_disp);
        end
    endtask

    task automatic test_abort;
        score   = 14'd4321;
        count_h = 11'd0;
        count_v = 10'd0;
        @(posedge clk); #1;
        count_h = 11'd1;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0 || bcd_disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_now: busy=%b bcd_disp=%h, expected 0 0000", busy, bcd_disp);
        end
        repeat (2) begin @(posedge clk); #1; end
        n_chk++;
        if (busy !== 1'b0 || bcd_disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_hold: busy=%b bcd_disp=%h, expected 0 0000", busy, bcd_disp);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        do_convert(14'd4321);
        n_chk++;
        if (busy !== 1'b0 || bcd_disp !== 16'h4321) begin
            n_fail++;
            $display("FAIL abort_recover: busy=%b bcd_disp=%h, expected 0 4321", busy, bcd_disp);
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_render_37();
        test_zero();
        test_inner_zero();
        test_midframe();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
